// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit:
// FSM states, opcode/funct values and datapath select codes.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_WB_R     = 4'd3,
        S_EXEC_I   = 4'd4,
        S_WB_I     = 4'd5,
        S_MEM_ADDR = 4'd6,
        S_MEM_RD   = 4'd7,
        S_WB_LW    = 4'd8,
        S_MEM_WR   = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b000001;
    localparam logic [5:0] OP_LW   = 6'b000011;
    localparam logic [5:0] OP_SW   = 6'b000100;
    localparam logic [5:0] OP_BEQ  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000110;

    localparam logic [5:0] FN_ADD = 6'b000000;
    localparam logic [5:0] FN_SUB = 6'b000001;
    localparam logic [5:0] FN_AND = 6'b000010;
    localparam logic [5:0] FN_OR  = 6'b000011;
    localparam logic [5:0] FN_SLT = 6'b000101;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_SLT = 3'd4;

    localparam logic [1:0] PCS_ALU    = 2'd0;
    localparam logic [1:0] PCS_ALUOUT = 2'd1;
    localparam logic [1:0] PCS_JUMP   = 2'd2;

    localparam logic [1:0] ASB_B       = 2'd0;
    localparam logic [1:0] ASB_FOUR    = 2'd1;
    localparam logic [1:0] ASB_IMM     = 2'd2;
    localparam logic [1:0] ASB_IMM_SL2 = 2'd3;

    function automatic logic is_mem_op(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_alu_decoder.sv
// R-type funct to ALU operation decode; unknown funct yields
// add with funct_valid low.
module mips_alu_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] alu_ctrl,
    output logic       funct_valid
);

    always_comb begin
        alu_ctrl    = ALU_ADD;
        funct_valid = 1'b1;
        case (funct)
            FN_ADD:  alu_ctrl = ALU_ADD;
            FN_SUB:  alu_ctrl = ALU_SUB;
            FN_AND:  alu_ctrl = ALU_AND;
            FN_OR:   alu_ctrl = ALU_OR;
            FN_SLT:  alu_ctrl = ALU_SLT;
            default: funct_valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences the shared datapath and
// counts retired instructions.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_read,
    output logic             mem_write,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic [1:0]       pc_src,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_ctrl,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instr_count
);

    state_t           r_state;
    state_t           w_next;
    logic             w_retire;
    logic [CNT_W-1:0] r_count;
    logic [2:0]       w_fn_alu;
    logic             w_fn_valid;
    logic             w_unused_zero;

    // The branch decision is taken by the datapath via pc_write_cond.
    assign w_unused_zero = zero;

    mips_alu_decoder u_alu_dec (
        .funct       (funct),
        .alu_ctrl    (w_fn_alu),
        .funct_valid (w_fn_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
            r_count <= '0;
        end else begin
            r_state <= w_next;
            if (w_retire)
                r_count <= r_count + CNT_W'(1);
        end
    end

    assign instr_count = rst ? '0 : r_count;

    always_comb begin
        w_next        = r_state;
        w_retire      = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        iord          = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_src        = PCS_ALU;
        alu_src_a     = 1'b0;
        alu_src_b     = ASB_B;
        alu_ctrl      = ALU_ADD;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        illegal_op    = 1'b0;

        unique case (r_state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = ASB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready)
                    w_next = S_DECODE;
            end
            S_DECODE: begin
                alu_src_b = ASB_IMM_SL2;
                case (opcode)
                    OP_R:    w_next = S_EXEC_R;
                    OP_ADDI: w_next = S_EXEC_I;
                    OP_LW,
                    OP_SW:   w_next = S_MEM_ADDR;
                    OP_BEQ:  w_next = S_BRANCH;
                    OP_J:    w_next = S_JUMP;
                    default: begin
                        illegal_op = 1'b1;
                        w_next     = S_FETCH;
                    end
                endcase
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_src_b = ASB_B;
                alu_ctrl  = w_fn_alu;
                if (w_fn_valid) begin
                    w_next = S_WB_R;
                end else begin
                    illegal_op = 1'b1;
                    w_next     = S_FETCH;
                end
            end
            S_WB_R: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                w_retire  = 1'b1;
                w_next    = S_FETCH;
            end
            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = ASB_IMM;
                w_next    = S_WB_I;
            end
            S_WB_I: begin
                reg_write = 1'b1;
                w_retire  = 1'b1;
                w_next    = S_FETCH;
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = ASB_IMM;
                if (is_mem_op(opcode) && opcode == OP_LW)
                    w_next = S_MEM_RD;
                else
                    w_next = S_MEM_WR;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (mem_ready)
                    w_next = S_WB_LW;
            end
            S_WB_LW: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                w_retire   = 1'b1;
                w_next     = S_FETCH;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                if (mem_ready) begin
                    w_retire = 1'b1;
                    w_next   = S_FETCH;
                end
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_src_b     = ASB_B;
                alu_ctrl      = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_src        = PCS_ALUOUT;
                w_retire      = 1'b1;
                w_next        = S_FETCH;
            end
            S_JUMP: begin
                pc_write = 1'b1;
                pc_src   = PCS_JUMP;
                w_retire = 1'b1;
                w_next   = S_FETCH;
            end
            default: w_next = S_FETCH;
        endcase

        // Reset dominates: abandon any access and suppress all strobes.
        if (rst) begin
            w_retire      = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            iord          = 1'b0;
            ir_write      = 1'b0;
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            pc_src        = PCS_ALU;
            alu_src_a     = 1'b0;
            alu_src_b     = ASB_B;
            alu_ctrl      = ALU_ADD;
            reg_dst       = 1'b0;
            mem_to_reg    = 1'b0;
            reg_write     = 1'b0;
            illegal_op    = 1'b0;
        end
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for the multi-cycle MIPS control FSM using
// directed instruction sequences and a narrow counter to hit wrap.
module tb_mips_multicycle_ctrl;

    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [5:0]    opcode;
    logic [5:0]    funct;
    logic          zero;
    logic          mem_ready;
    logic          mem_read, mem_write, iord, ir_write, pc_write;
    logic          pc_write_cond, alu_src_a, reg_dst, mem_to_reg;
    logic          reg_write, illegal_op;
    logic [1:0]    pc_src, alu_src_b;
    logic [2:0]    alu_ctrl;
    logic [CW-1:0] instr_count;

    typedef struct {
        logic [17:0]   ctrl;
        logic [CW-1:0] cnt;
        string         name;
    } exp_t;

    exp_t          sb[$];
    int            checks = 0;
    int            failures = 0;
    logic [CW-1:0] ecnt;

    mips_multicycle_ctrl #(.CNT_W(CW)) dut (
        .clk           (clk),
        .rst           (rst),
        .opcode        (opcode),
        .funct         (funct),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .iord          (iord),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .pc_src        (pc_src),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_ctrl      (alu_ctrl),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .reg_write     (reg_write),
        .illegal_op    (illegal_op),
        .instr_count   (instr_count)
    );

    always #5 clk = ~clk;

    // Field order: mr mw iord irw pcw pcwc pcs asa asb alu rd m2r rw ill
    function automatic logic [17:0] mk(
        input logic mr, input logic mw, input logic io,
        input logic irw, input logic pcw, input logic pcwc,
        input logic [1:0] pcs, input logic asa, input logic [1:0] asb,
        input logic [2:0] alu, input logic rd, input logic m2r,
        input logic rw, input logic ill);
        return {mr, mw, io, irw, pcw, pcwc, pcs, asa, asb, alu,
                rd, m2r, rw, ill};
    endfunction

    logic [17:0] ZERO, F_RDY, F_STL, DEC, DEC_ILL, EXI, WBI;
    logic [17:0] EXR_ADD, EXR_SLT, EXR_ILL, WBR, MA, MRD, WBLW;
    logic [17:0] MWR, BR, JMP;

    task automatic step(input logic r, input logic [5:0] op,
                        input logic [5:0] fn, input logic z,
                        input logic rdy, input logic [17:0] ex,
                        input string nm);
        exp_t e;
        rst       = r;
        opcode    = op;
        funct     = fn;
        zero      = z;
        mem_ready = rdy;
        e.ctrl    = ex;
        e.cnt     = ecnt;
        e.name    = nm;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        exp_t        e;
        logic [17:0] act;
        forever begin
            @(negedge clk);
            act = {mem_read, mem_write, iord, ir_write, pc_write,
                   pc_write_cond, pc_src, alu_src_a, alu_src_b, alu_ctrl,
                   reg_dst, mem_to_reg, reg_write, illegal_op};
            checks++;
            if ((mem_read && mem_write) ||
                (reg_write && (mem_read || mem_write))) begin
                failures++;
                $display("FAIL strobe_excl act=%b", act);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (act !== e.ctrl) begin
                    failures++;
                    $display("FAIL %s ctrl act=%b exp=%b",
                             e.name, act, e.ctrl);
                end
                checks++;
                if (instr_count !== e.cnt) begin
                    failures++;
                    $display("FAIL %s count act=%0d exp=%0d",
                             e.name, instr_count, e.cnt);
                end
            end
        end
    end

    initial begin : stim
        ZERO    = '0;
        F_RDY   = mk(1,0,0,1,1,0,2'd0,0,2'd1,3'd0,0,0,0,0);
        F_STL   = mk(1,0,0,0,0,0,2'd0,0,2'd1,3'd0,0,0,0,0);
        DEC     = mk(0,0,0,0,0,0,2'd0,0,2'd3,3'd0,0,0,0,0);
        DEC_ILL = mk(0,0,0,0,0,0,2'd0,0,2'd3,3'd0,0,0,0,1);
        EXI     = mk(0,0,0,0,0,0,2'd0,1,2'd2,3'd0,0,0,0,0);
        WBI     = mk(0,0,0,0,0,0,2'd0,0,2'd0,3'd0,0,0,1,0);
        EXR_ADD = mk(0,0,0,0,0,0,2'd0,1,2'd0,3'd0,0,0,0,0);
        EXR_SLT = mk(0,0,0,0,0,0,2'd0,1,2'd0,3'd4,0,0,0,0);
        EXR_ILL = mk(0,0,0,0,0,0,2'd0,1,2'd0,3'd0,0,0,0,1);
        WBR     = mk(0,0,0,0,0,0,2'd0,0,2'd0,3'd0,1,0,1,0);
        MA      = mk(0,0,0,0,0,0,2'd0,1,2'd2,3'd0,0,0,0,0);
        MRD     = mk(1,0,1,0,0,0,2'd0,0,2'd0,3'd0,0,0,0,0);
        WBLW    = mk(0,0,0,0,0,0,2'd0,0,2'd0,3'd0,0,1,1,0);
        MWR     = mk(0,1,1,0,0,0,2'd0,0,2'd0,3'd0,0,0,0,0);
        BR      = mk(0,0,0,0,0,1,2'd1,1,2'd0,3'd1,0,0,0,0);
        JMP     = mk(0,0,0,0,1,0,2'd2,0,2'd0,3'd0,0,0,0,0);
        ecnt    = '0;

        rst = 1'b1; opcode = '0; funct = '0; zero = 1'b0;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++)
            step(1, 6'd0, 6'd0, 0, 1, ZERO, "reset");

        // addi
        step(0, 6'b000001, 6'd0, 0, 1, F_RDY, "addi_f");
        step(0, 6'b000001, 6'd0, 0, 1, DEC,   "addi_d");
        step(0, 6'b000001, 6'd0, 0, 1, EXI,   "addi_ex");
        step(0, 6'b000001, 6'd0, 0, 1, WBI,   "addi_wb");
        ecnt++;

        // lw with 2 stall cycles in MEM_RD
        step(0, 6'b000011, 6'd0, 0, 1, F_RDY, "lw_f");
        step(0, 6'b000011, 6'd0, 0, 1, DEC,   "lw_d");
        step(0, 6'b000011, 6'd0, 0, 1, MA,    "lw_ma");
        step(0, 6'b000011, 6'd0, 0, 0, MRD,   "lw_stall1");
        step(0, 6'b000011, 6'd0, 0, 0, MRD,   "lw_stall2");
        step(0, 6'b000011, 6'd0, 0, 1, MRD,   "lw_rd");
        step(0, 6'b000011, 6'd0, 0, 1, WBLW,  "lw_wb");
        ecnt++;

        // sw with a fetch stall
        step(0, 6'b000100, 6'd0, 0, 0, F_STL, "sw_fstall");
        step(0, 6'b000100, 6'd0, 0, 1, F_RDY, "sw_f");
        step(0, 6'b000100, 6'd0, 0, 1, DEC,   "sw_d");
        step(0, 6'b000100, 6'd0, 0, 1, MA,    "sw_ma");
        step(0, 6'b000100, 6'd0, 0, 1, MWR,   "sw_wr");
        ecnt++;

        // beq taken and not taken
        step(0, 6'b000101, 6'd0, 1, 1, F_RDY, "beq1_f");
        step(0, 6'b000101, 6'd0, 1, 1, DEC,   "beq1_d");
        step(0, 6'b000101, 6'd0, 1, 1, BR,    "beq1_br");
        ecnt++;
        step(0, 6'b000101, 6'd0, 0, 1, F_RDY, "beq0_f");
        step(0, 6'b000101, 6'd0, 0, 1, DEC,   "beq0_d");
        step(0, 6'b000101, 6'd0, 0, 1, BR,    "beq0_br");
        ecnt++;

        // j with target 3
        step(0, 6'b000110, 6'd3, 0, 1, F_RDY, "j_f");
        step(0, 6'b000110, 6'd3, 0, 1, DEC,   "j_d");
        step(0, 6'b000110, 6'd3, 0, 1, JMP,   "j_jmp");
        ecnt++;

        // all-zero nop, then slt (retirement wraps the 3-bit counter)
        step(0, 6'd0, 6'd0, 0, 1, F_RDY,   "nop_f");
        step(0, 6'd0, 6'd0, 0, 1, DEC,     "nop_d");
        step(0, 6'd0, 6'd0, 0, 1, EXR_ADD, "nop_ex");
        step(0, 6'd0, 6'd0, 0, 1, WBR,     "nop_wb");
        ecnt++;
        step(0, 6'd0, 6'b000101, 0, 1, F_RDY,   "slt_f");
        step(0, 6'd0, 6'b000101, 0, 1, DEC,     "slt_d");
        step(0, 6'd0, 6'b000101, 0, 1, EXR_SLT, "slt_ex");
        step(0, 6'd0, 6'b000101, 0, 1, WBR,     "slt_wb");
        ecnt++;

        // illegal opcode, then illegal funct
        step(0, 6'b111111, 6'd0, 0, 1, F_RDY,   "badop_f");
        step(0, 6'b111111, 6'd0, 0, 1, DEC_ILL, "badop_d");
        step(0, 6'd0, 6'b111111, 0, 1, F_RDY,   "badfn_f");
        step(0, 6'd0, 6'b111111, 0, 1, DEC,     "badfn_d");
        step(0, 6'd0, 6'b111111, 0, 1, EXR_ILL, "badfn_ex");

        // reset during a stalled store
        step(0, 6'b000100, 6'd0, 0, 1, F_RDY, "swr_f");
        step(0, 6'b000100, 6'd0, 0, 1, DEC,   "swr_d");
        step(0, 6'b000100, 6'd0, 0, 1, MA,    "swr_ma");
        step(0, 6'b000100, 6'd0, 0, 0, MWR,   "swr_stall");
        step(1, 6'b000100, 6'd0, 0, 0, ZERO,  "swr_rst");
        ecnt = '0;
        step(0, 6'b000100, 6'd0, 0, 0, F_STL, "post_rst_f");
        step(0, 6'b000001, 6'd0, 0, 1, F_RDY, "post_rst_f2");

        for (int i = 0; i < 10 && sb.size() > 0; i++)
            @(negedge clk);
        if (sb.size() > 0) begin
            failures++;
            $display("FAIL drain act=%0d exp=0", sb.size());
        end
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
